// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational from the fetch PC; decode-stage resolutions train the table.
module branch_predictor #(
    parameter int PC_WIDTH = 16,
    parameter int ENTRIES  = 8,
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] lookup_pc,
    output logic                pred_hit,
    output logic                pred_taken,
    output logic [PC_WIDTH-1:0] pred_next_pc,
    input  logic                upd_en,
    input  logic [PC_WIDTH-1:0] upd_pc,
    input  logic                upd_taken,
    input  logic                upd_jump,
    input  logic [PC_WIDTH-1:0] upd_target,
    input  logic                inv
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX - 1;

    localparam logic [CTR_BITS-1:0] CTR_ZERO = {CTR_BITS{1'b0}};
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1'b1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WT   = CTR_ONE << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WNT  = CTR_WT - CTR_ONE;
    localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(2'd2);

    logic                valid_r  [ENTRIES];
    logic [TAG_W-1:0]    tag_r    [ENTRIES];
    logic [PC_WIDTH-1:0] target_r [ENTRIES];
    logic [CTR_BITS-1:0] ctr_r    [ENTRIES];

    logic [IDX-1:0]      lkp_idx_s;
    logic [TAG_W-1:0]    lkp_tag_s;
    logic [IDX-1:0]      upd_idx_s;
    logic [TAG_W-1:0]    upd_tag_s;
    logic                upd_hit_s;
    logic                wr_en_s;
    logic [CTR_BITS-1:0] new_ctr_s;
    logic [PC_WIDTH-1:0] new_target_s;

    assign lkp_idx_s = lookup_pc[IDX:1];
    assign lkp_tag_s = lookup_pc[PC_WIDTH-1:IDX+1];
    assign upd_idx_s = upd_pc[IDX:1];
    assign upd_tag_s = upd_pc[PC_WIDTH-1:IDX+1];
    assign upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);

    // Fetch-side prediction, read from the pre-update table contents (no bypass).
    always_comb begin
        pred_hit     = valid_r[lkp_idx_s] && (tag_r[lkp_idx_s] == lkp_tag_s);
        pred_taken   = pred_hit && ctr_r[lkp_idx_s][CTR_BITS-1];
        pred_next_pc = lookup_pc + PC_STEP;
        if (pred_taken) begin
            pred_next_pc = target_r[lkp_idx_s];
        end else begin
            pred_next_pc = lookup_pc + PC_STEP;
        end
    end

    // Training decision; a not-taken jump is treated as taken.
    always_comb begin
        wr_en_s      = 1'b0;
        new_ctr_s    = ctr_r[upd_idx_s];
        new_target_s = target_r[upd_idx_s];
        if (upd_en && !inv) begin
            if (upd_hit_s) begin
                wr_en_s = 1'b1;
                if (upd_jump) begin
                    new_ctr_s    = CTR_MAX;
                    new_target_s = upd_target;
                end else if (upd_taken) begin
                    new_ctr_s    = (ctr_r[upd_idx_s] == CTR_MAX) ? CTR_MAX
                                                                 : ctr_r[upd_idx_s] + CTR_ONE;
                    new_target_s = upd_target;
                end else begin
                    new_ctr_s    = (ctr_r[upd_idx_s] == CTR_ZERO) ? CTR_ZERO
                                                                  : ctr_r[upd_idx_s] - CTR_ONE;
                end
            end else if (upd_taken || upd_jump) begin
                wr_en_s      = 1'b1;
                new_ctr_s    = upd_jump ? CTR_MAX : CTR_WT;
                new_target_s = upd_target;
            end else begin
                wr_en_s = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Table storage: async reset, invalidate-all beats any same-cycle update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= {PC_WIDTH{1'b0}};
                ctr_r[i]    <= CTR_WNT;
            end
        end else if (inv) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
            end
        end else if (wr_en_s) begin
            valid_r[upd_idx_s]  <= 1'b1;
            tag_r[upd_idx_s]    <= upd_tag_s;
            target_r[upd_idx_s] <= new_target_s;
            ctr_r[upd_idx_s]    <= new_ctr_s;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic checked against a table model kept in plain integers.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [15:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [15:0] pred_next_pc;
    logic        upd_en;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic        upd_jump;
    logic [15:0] upd_target;
    logic        inv;

    int tests;
    int fails;

    int m_valid  [8];
    int m_tag    [8];
    int m_target [8];
    int m_ctr    [8];

    branch_predictor #(.PC_WIDTH(16), .ENTRIES(8), .CTR_BITS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_pc    (lookup_pc),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_next_pc (pred_next_pc),
        .upd_en       (upd_en),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_jump     (upd_jump),
        .upd_target   (upd_target),
        .inv          (inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i]  = 0;
            m_tag[i]    = 0;
            m_target[i] = 0;
            m_ctr[i]    = 1;
        end
    endtask

    // Expected prediction for the current lookup_pc from the model.
    task automatic check_lookup(input string name);
        int  i;
        bit  h;
        bit  t;
        logic [15:0] n;
        i = int'(lookup_pc[3:1]);
        h = (m_valid[i] == 1) && (m_tag[i] == int'(lookup_pc[15:4]));
        t = h && (m_ctr[i] >= 2);
        n = t ? 16'(m_target[i]) : 16'(lookup_pc + 16'd2);
        check({name, ".hit"},   {31'd0, pred_hit},   {31'd0, h});
        check({name, ".taken"}, {31'd0, pred_taken}, {31'd0, t});
        check({name, ".next"},  {16'd0, pred_next_pc}, {16'd0, n});
    endtask

    task automatic model_update(input bit en, input logic [15:0] pc, input bit tk,
                                input bit jp, input logic [15:0] tgt, input bit iv);
        int i;
        bit hit;
        i   = int'(pc[3:1]);
        hit = (m_valid[i] == 1) && (m_tag[i] == int'(pc[15:4]));
        if (iv) begin
            for (int k = 0; k < 8; k++) m_valid[k] = 0;
        end else if (en) begin
            if (hit) begin
                if (jp) begin
                    m_ctr[i] = 3; m_target[i] = int'(tgt);
                end else if (tk) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_target[i] = int'(tgt);
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (tk || jp) begin
                m_valid[i]  = 1;
                m_tag[i]    = int'(pc[15:4]);
                m_target[i] = int'(tgt);
                m_ctr[i]    = jp ? 3 : 2;
            end
        end
    endtask

    // One clock: drive, check the pre-edge prediction, then advance model and DUT.
    task automatic cycle(input string name, input logic [15:0] lpc, input bit en,
                         input logic [15:0] pc, input bit tk, input bit jp,
                         input logic [15:0] tgt, input bit iv);
        lookup_pc  = lpc;
        upd_en     = en;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_jump   = jp;
        upd_target = tgt;
        inv        = iv;
        #1;
        check_lookup(name);
        @(posedge clk);
        model_update(en, pc, tk, jp, tgt, iv);
        #1;
        upd_en = 1'b0;
        inv    = 1'b0;
    endtask

    initial begin
        bit hyst_tk  [5];
        bit hyst_exp [5];
        logic [15:0] r_lpc, r_pc, r_tgt;
        bit r_en, r_tk, r_jp, r_iv;
        tests = 0;
        fails = 0;
        hyst_tk  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        hyst_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b0; lookup_pc = 16'h0010; upd_en = 1'b0; upd_pc = 16'h0000;
        upd_taken = 1'b0; upd_jump = 1'b0; upd_target = 16'h0000; inv = 1'b0;
        model_reset();
        #1;
        check("rst_low.hit",   {31'd0, pred_hit},   32'd0);
        check("rst_low.taken", {31'd0, pred_taken}, 32'd0);
        check("rst_low.next",  {16'd0, pred_next_pc}, 32'h0012);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("reset.hit",  {31'd0, pred_hit}, 32'd0);
        check("reset.next", {16'd0, pred_next_pc}, 32'h0012);
        @(posedge clk); #1;

        // Allocation: same-cycle lookup misses, next cycle hits.
        lookup_pc = 16'h0010; upd_en = 1'b1; upd_pc = 16'h0010;
        upd_taken = 1'b1; upd_jump = 1'b0; upd_target = 16'h0040;
        #1;
        check("alloc.same_cycle_hit", {31'd0, pred_hit}, 32'd0);
        @(posedge clk);
        model_update(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0040, 1'b0);
        #1; upd_en = 1'b0;
        #1;
        check("alloc.hit",   {31'd0, pred_hit},   32'd1);
        check("alloc.taken", {31'd0, pred_taken}, 32'd1);
        check("alloc.next",  {16'd0, pred_next_pc}, 32'h0040);

        for (int k = 0; k < 5; k++) begin
            cycle("hyst_step", 16'h0010, 1'b1, 16'h0010, hyst_tk[k], 1'b0, 16'h0040, 1'b0);
            lookup_pc = 16'h0010;
            #1;
            check($sformatf("hyst.taken%0d", k), {31'd0, pred_taken}, {31'd0, hyst_exp[k]});
        end

        cycle("alias_upd", 16'h0110, 1'b1, 16'h0110, 1'b1, 1'b1, 16'h0200, 1'b0);
        lookup_pc = 16'h0010; #1;
        check("alias.old_hit", {31'd0, pred_hit}, 32'd0);
        lookup_pc = 16'h0110; #1;
        check("alias.taken", {31'd0, pred_taken}, 32'd1);
        check("alias.next",  {16'd0, pred_next_pc}, 32'h0200);

        lookup_pc = 16'hFFFE; #1;
        check("wrap.hit",  {31'd0, pred_hit}, 32'd0);
        check("wrap.next", {16'd0, pred_next_pc}, 32'h0000);

        cycle("inv_upd", 16'h0020, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0080, 1'b1);
        lookup_pc = 16'h0020; #1;
        check("inv.hit_0020", {31'd0, pred_hit}, 32'd0);
        lookup_pc = 16'h0110; #1;
        check("inv.hit_0110", {31'd0, pred_hit}, 32'd0);

        // Asynchronous reset between edges, discarding a pending update.
        cycle("realloc", 16'h0010, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0040, 1'b0);
        lookup_pc = 16'h0010; #1;
        check("pre_rst.hit", {31'd0, pred_hit}, 32'd1);
        upd_en = 1'b1; upd_pc = 16'h0030; upd_taken = 1'b1; upd_jump = 1'b0;
        upd_target = 16'h0300;
        #1; rst = 1'b0; #1;
        check("mid_rst.hit",  {31'd0, pred_hit}, 32'd0);
        check("mid_rst.next", {16'd0, pred_next_pc}, 32'h0012);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1; upd_en = 1'b0;
        lookup_pc = 16'h0030; #1;
        check("mid_rst.discard", {31'd0, pred_hit}, 32'd0);
        @(posedge clk); #1;

        for (int n = 0; n < 400; n++) begin
            r_pc  = 16'(($urandom_range(0, 3) << 4) | ($urandom_range(0, 7) << 1));
            r_lpc = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                    : 16'(($urandom_range(0, 3) << 4) | ($urandom_range(0, 7) << 1));
            r_tgt = 16'($urandom);
            r_en  = ($urandom_range(0, 3) != 0);
            r_jp  = ($urandom_range(0, 4) == 0);
            r_tk  = r_jp ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
            r_iv  = ($urandom_range(0, 39) == 0);
            cycle("rand", r_lpc, r_en, r_pc, r_tk, r_jp, r_tgt, r_iv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
